inv_bist_ctrl: RTL and testbench
================================

// Module: inv_bist_ctrl
// PURPOSE
//   Built-in self-test controller for the CMOS inverter cell.
//   - Upstream: drives the inverter input x (x_drive).
//   - Downstream: samples the inverter output f (f_sense).
//   - Applies a fixed-length pattern, waits a settle time per vector, checks f == ~x
//     and counts mismatches.
//   - Sits between the chip test-control logic and the transistor-level inverter under test.
// PARAMETERS
//   SETTLE_CYCLES  2   clock cycles between driving x and sampling f (0 allowed)
//   PATTERN_LEN    16  number of test vectors per run; legal range 2..256
//   ERR_W          8   width of the mismatch counter
// PORTS
//   clk       in   1      single clock; all state on rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   start     in   1      request a test run; sampled only in IDLE or DONE
//   f_sense   in   1      inverter output f
//   x_drive   out  1      inverter input x, registered
//   busy      out  1      high while a run is in progress
//   done      out  1      high from run completion until the next accepted start
//   pass      out  1      valid while done: 1 when err_cnt == 0
//   err_cnt   out  ERR_W  mismatch count for the current/last run, saturating
// BEHAVIOUR
//   Reset (rst_n low, async):
//   - All outputs 0; state IDLE; vec_cnt, settle counter and err_cnt cleared.
//   - LFSR loaded with 8'hA5. Sync flops (if present) set to 1.
//   - Reset mid-run aborts the run: no done, no pass.
//   FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
//   - IDLE/DONE, start=1 at edge E0:
//     go to DRIVE; busy=1; done=0; pass=0; err_cnt=0; vec_cnt=0; LFSR=8'hA5.
//   - DRIVE (1 cycle): x_drive <= vector bit for vec_cnt.
//     - vec 0 drives 0; vec 1 drives 1; later vectors drive lfsr[0].
//     - Load the settle counter with SETTLE_CYCLES. Go to SETTLE, or to SAMPLE
//       if the load value is 0.
//   - SETTLE: decrement each cycle; go to SAMPLE at the edge where the count reaches 0.
//   - SAMPLE (1 cycle):
//     - Compare f_s against ~x_drive. On mismatch, err_cnt += 1, saturating at 2^ERR_W-1.
//     - Advance the LFSR only when vec_cnt >= 1.
//     - If vec_cnt == PATTERN_LEN-1: go to DONE. Otherwise vec_cnt++ and go to DRIVE.
//   - DONE: busy=0; done=1; pass=(err_cnt==0). Hold until reset or an accepted start.
//   - x_drive holds its value through SETTLE and SAMPLE. It returns to 0 on entry to
//     DONE or IDLE.
//   LFSR: 8-bit Fibonacci; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
//   Timing:
//   - Each vector takes SETTLE_CYCLES+2 cycles.
//   - DONE is entered at edge E0 + PATTERN_LEN*(SETTLE_CYCLES+2) (default: E0+64).
//   Boundary conditions:
//   - start while busy: ignored, with no effect on state or counters.
//   - start held high: exactly one run per accepted start. A restart from DONE clears
//     done, pass and err_cnt at the accepting edge.
//   - err_cnt saturated: stays at its maximum; pass=0.
// CONFIGURATION
//   INV_BIST_FSYNC_EN
//   - Defined:
//     - f_sense passes through a 2-flop synchronizer (reset value 1) to form f_s.
//     - The settle counter is loaded with SETTLE_CYCLES+2.
//     - Per-vector time is SETTLE_CYCLES+4 cycles; default run length is 96 cycles.
//   - Undefined: f_s = f_sense directly; timing as above.
// TESTING
//   1 Ideal inverter model (f_sense=~x_drive), start pulse at E0
//     -> busy for 64 cycles; done=1 at E0+64; pass=1; err_cnt=0.
//   2 Buffer model (f_sense=x_drive)
//     -> err_cnt=16, pass=0.
//   3 f_sense stuck at 0, then (separate run) stuck at 1
//     -> each run err_cnt>=1 and pass=0; the two counts sum to 16.
//   4 Ideal model; extra start pulse at E0+10
//     -> ignored; done still at E0+64; err_cnt=0.
//   5 rst_n low at E0+30 for 3 cycles
//     -> outputs 0 immediately (async); after release, a new start gives done at +64, pass=1.
//   6 ERR_W=2, buffer model
//     -> err_cnt saturates at 3, pass=0.
//     Repeat test 1 with INV_BIST_FSYNC_EN defined -> done at E0+96, pass=1.

Source files
------------

// File: rtl/inv_bist_ctrl.sv
// inv_bist_ctrl: built-in self-test controller for a CMOS inverter cell.
// The controller drives the inverter input (x_drive) with a fixed-length
// pattern. It waits a settle time for each vector, then checks that the
// inverter output equals ~x_drive and counts any mismatches.
// Optional feature macro: INV_BIST_FSYNC_EN. When it is defined, f_sense is
// passed through a 2-flop synchronizer and the settle time is extended by
// two cycles to cover the synchronizer latency.
module inv_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PATTERN_LEN   = 16,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f_sense,
  output logic             x_drive,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRIVE  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

`ifdef INV_BIST_FSYNC_EN
  localparam int SETTLE_LOAD = SETTLE_CYCLES + 2;
`else
  localparam int SETTLE_LOAD = SETTLE_CYCLES;
`endif

  localparam int VEC_W = (PATTERN_LEN > 2) ? $clog2(PATTERN_LEN) : 1;
  localparam int SET_W = (SETTLE_LOAD > 1) ? $clog2(SETTLE_LOAD + 1) : 1;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(PATTERN_LEN - 1);
  localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_LOAD);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [7:0]       LFSR_SEED = 8'hA5;

  logic [2:0]       state_q, state_d;
  logic [VEC_W-1:0] vecCnt_q, vecCnt_d;
  logic [SET_W-1:0] settleCnt_q, settleCnt_d;
  logic [ERR_W-1:0] errCnt_q, errCnt_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             xDrive_q, xDrive_d;
  logic             f_s;

`ifdef INV_BIST_FSYNC_EN
  logic syncA_q, syncB_q;

  // Two-flop synchronizer for the analog-side inverter output; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA_q <= 1'b1;
      syncB_q <= 1'b1;
    end else begin
      syncA_q <= f_sense;
      syncB_q <= syncA_q;
    end
  end

  assign f_s = syncB_q;
`else
  assign f_s = f_sense;
`endif

  // Next-state logic: vector sequencing, settle timing, mismatch counting.
  always_comb begin
    state_d     = state_q;
    vecCnt_d    = vecCnt_q;
    settleCnt_d = settleCnt_q;
    errCnt_d    = errCnt_q;
    lfsr_d      = lfsr_q;
    xDrive_d    = xDrive_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = DRIVE;
          vecCnt_d = '0;
          errCnt_d = '0;
          lfsr_d   = LFSR_SEED;
        end
      end
      DRIVE: begin
        if (vecCnt_q == '0) begin
          xDrive_d = 1'b0;
        end else if (vecCnt_q == VEC_ONE) begin
          xDrive_d = 1'b1;
        end else begin
          xDrive_d = lfsr_q[0];
        end
        settleCnt_d = SET_LOAD;
        state_d     = (SET_LOAD == '0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        settleCnt_d = settleCnt_q - SET_ONE;
        if (settleCnt_q <= SET_ONE) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if ((f_s == xDrive_q) && (errCnt_q != ERR_MAX)) begin
          errCnt_d = errCnt_q + 1'b1;
        end
        if (vecCnt_q != '0) begin
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
        if (vecCnt_q == LAST_VEC) begin
          state_d  = DONE;
          xDrive_d = 1'b0;
        end else begin
          vecCnt_d = vecCnt_q + 1'b1;
          state_d  = DRIVE;
        end
      end
      default: begin
        state_d  = IDLE;
        xDrive_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vecCnt_q    <= '0;
      settleCnt_q <= '0;
      errCnt_q    <= '0;
      lfsr_q      <= LFSR_SEED;
      xDrive_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      vecCnt_q    <= vecCnt_d;
      settleCnt_q <= settleCnt_d;
      errCnt_q    <= errCnt_d;
      lfsr_q      <= lfsr_d;
      xDrive_q    <= xDrive_d;
    end
  end

  assign x_drive = xDrive_q;
  assign busy    = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
  assign done    = (state_q == DONE);
  assign pass    = (state_q == DONE) && (errCnt_q == '0);
  assign err_cnt = errCnt_q;

endmodule

// File: tb/tb_inv_bist_ctrl.sv
// Testbench for inv_bist_ctrl.
// A behavioural model derives the expected vector bits and mismatch counts.
// The inverter under test is modelled in one of several ways:
// ideal with random flipped vectors, buffer, stuck-at-0, or stuck-at-1.
// A second instance with ERR_W=2 always sees a buffer, so it exercises
// counter saturation.
module tb_inv_bist_ctrl;

  localparam int SETTLE = 2;
  localparam int NVEC   = 16;
`ifdef INV_BIST_FSYNC_EN
  localparam int PER = SETTLE + 4;
`else
  localparam int PER = SETTLE + 2;
`endif
  localparam int RUN_LEN = NVEC * PER;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       fSense;
  logic       xDrive, busy, done, pass;
  logic [7:0] errCnt;
  logic       xDrive2, busy2, done2, pass2;
  logic [1:0] errCnt2;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          e0Cyc = 0;
  int          mode  = 0;
  logic [15:0] flipMask = '0;
  logic        flipBit;

  inv_bist_ctrl #(.SETTLE_CYCLES(SETTLE), .PATTERN_LEN(NVEC), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_sense(fSense),
    .x_drive(xDrive), .busy(busy), .done(done), .pass(pass), .err_cnt(errCnt)
  );

  inv_bist_ctrl #(.SETTLE_CYCLES(SETTLE), .PATTERN_LEN(NVEC), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .f_sense(xDrive2),
    .x_drive(xDrive2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(errCnt2)
  );

  always #5 clk = ~clk;

  // Free-running cycle count so the inverter model knows which vector is active.
  always @(posedge clk) cyc <= cyc + 1;

  // Select the flip bit for the vector currently being applied.
  always_comb begin
    int rel;
    int k;
    rel = cyc - e0Cyc;
    k = (rel < 1) ? 0 : (rel - 1) / PER;
    if (k > NVEC - 1) k = NVEC - 1;
    flipBit = flipMask[k];
  end

  // Inverter model driving f_sense.
  always_comb begin
    case (mode)
      0:       fSense = ~xDrive ^ flipBit;
      1:       fSense = xDrive;
      2:       fSense = 1'b0;
      default: fSense = 1'b1;
    endcase
  end

  // Bit applied for vector k: 0, 1, then the LFSR LSB after k-1 steps from 8'hA5.
  function automatic int vecBit(input int k);
    logic [7:0] l;
    if (k == 0) return 0;
    if (k == 1) return 1;
    l = 8'hA5;
    for (int s = 0; s < k - 1; s++) l = {l[6:0], ^(l & 8'b1011_1000)};
    return int'(l[0]);
  endfunction

  // Mismatches a whole run should produce for a given inverter model.
  function automatic int expectErr(input int m, input logic [15:0] fl, input int maxv);
    int cnt;
    int x;
    int f;
    cnt = 0;
    for (int k = 0; k < NVEC; k++) begin
      x = vecBit(k);
      case (m)
        0:       f = (1 - x) ^ int'(fl[k]);
        1:       f = x;
        2:       f = 0;
        default: f = 1;
      endcase
      if (f != 1 - x) cnt++;
    end
    return (cnt > maxv) ? maxv : cnt;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One complete run with the given inverter model and an optional stray start.
  task automatic applyStimulus(input int m, input logic [15:0] fl, input int extraAt);
    int expErr;
    @(negedge clk);
    mode = m;
    flipMask = fl;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0Cyc = cyc;
    checkOutput("accept_busy", int'(busy), 1);
    checkOutput("accept_done", int'(done), 0);
    checkOutput("accept_pass", int'(pass), 0);
    checkOutput("accept_err", int'(errCnt), 0);
    expErr = expectErr(m, fl, 255);
    for (int j = 1; j <= RUN_LEN; j++) begin
      start = (j == extraAt);
      @(posedge clk);
      #1;
      if ((j - 1) % PER == 0) checkOutput("x_vec", int'(xDrive), vecBit((j - 1) / PER));
      if (j == RUN_LEN - 1) begin
        checkOutput("busy_before_done", int'(busy), 1);
        checkOutput("done_early", int'(done), 0);
      end
      if (j == RUN_LEN) begin
        checkOutput("done", int'(done), 1);
        checkOutput("busy_end", int'(busy), 0);
        checkOutput("err_cnt", int'(errCnt), expErr);
        checkOutput("pass", int'(pass), (expErr == 0) ? 1 : 0);
        checkOutput("x_idle", int'(xDrive), 0);
        checkOutput("sat_done", int'(done2), 1);
        checkOutput("sat_err", int'(errCnt2), 3);
        checkOutput("sat_pass", int'(pass2), 0);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int e0;
    int e1;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_pass", int'(pass), 0);
    checkOutput("rst_err", int'(errCnt), 0);
    checkOutput("rst_x", int'(xDrive), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_no_start", int'(busy), 0);

    applyStimulus(0, 16'h0000, 0);
    applyStimulus(1, 16'h0000, 0);
    applyStimulus(2, 16'h0000, 0);
    applyStimulus(3, 16'h0000, 0);
    e0 = expectErr(2, 16'h0000, 255);
    e1 = expectErr(3, 16'h0000, 255);
    checkOutput("stuck_sum", e0 + e1, NVEC);
    applyStimulus(0, 16'h0000, 10);

    @(negedge clk);
    mode = 0;
    flipMask = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy", int'(busy), 0);
    checkOutput("async_done", int'(done), 0);
    checkOutput("async_x", int'(xDrive), 0);
    checkOutput("async_err", int'(errCnt), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("held_rst_done", int'(done), 0);
    rst_n = 1'b1;
    applyStimulus(0, 16'h0000, 0);

    for (int r = 0; r < 5; r++) begin
      applyStimulus(int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, RUN_LEN - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
